issue_stage: RTL

- Fetch/decode/operand-issue stage that sits directly upstream of the ALU. It drives the ALU's opcode, A, B, val, cin and fl inputs.
- Fetches 32-bit instruction words over a req/ack handshake, decodes them, and reads operands from a local 8x32 register file.
- Presents operands to the ALU, then writes the ALU result and flags back.
- Resolves unconditional and conditional direct/relative jumps locally. The ALU's internal PC and stack are not used.

---
 rtl/issue_stage_if.sv | 30 +++
 rtl/issue_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/issue_stage_if.sv
// Bundles the instruction-fetch handshake and the ALU operand/result bus
// between the issue stage (master) and the memory/ALU side (slave).
interface issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic [7:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_val;
  logic              alu_cin;
  logic              alu_fl;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        alu_flags;

  modport master (
    output imem_req, imem_addr, alu_opcode, alu_a, alu_b, alu_val, alu_cin, alu_fl,
    input  imem_ack, imem_rdata, alu_result, alu_flags
  );

  modport slave (
    input  imem_req, imem_addr, alu_opcode, alu_a, alu_b, alu_val, alu_cin, alu_fl,
    output imem_ack, imem_rdata, alu_result, alu_flags
  );
endinterface

// File: rtl/issue_stage.sv
// Fetch/decode/operand-issue stage in front of a combinational ALU.
// Fetches over req/ack, reads a local 8x32 register file, drives the ALU
// operands, writes the result and flags back, and resolves jumps locally.
module issue_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int NREG   = 8
) (
  input  logic            clkout,
  input  logic            rst,
  input  logic            run,
  issue_stage_if.master   bus,
  output logic [PC_W-1:0] pc_out,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, BRANCH, HALT
  } state_t;

  // Flag register bit positions, matching alu_flags order [Z C S P V].
  localparam int FZ = 4;
  localparam int FC = 3;
  localparam int FS = 2;
  localparam int FV = 0;

  localparam logic [7:0] OP_HALT = 8'd0;
  localparam logic [7:0] OP_JCP  = 8'd37;
  localparam logic [7:0] OP_JCD  = 8'd39;
  localparam logic [7:0] OP_MVR  = 8'd47;
  localparam logic [7:0] OP_JUA  = 8'd48;
  localparam logic [7:0] OP_JUP  = 8'd50;
  localparam logic [7:0] OP_JUD  = 8'd52;
  localparam logic [7:0] OP_NOP  = 8'd53;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [4:0]        flag_reg;
  logic [DATA_W-1:0] regs [NREG];

  logic [7:0]        opcode_r;
  logic [DATA_W-1:0] a_r, b_r, val_r;
  logic              cin_r, fl_r;

  logic [7:0]        ir_op;
  logic [2:0]        ir_rd, ir_rs, ir_cond;
  logic [DATA_W-1:0] ir_val;
  logic              is_alu_op, is_branch, is_illegal, cond_true;

  assign ir_op   = ir[31:24];
  assign ir_rd   = ir[23:21];
  assign ir_rs   = ir[20:18];
  assign ir_cond = ir[17:15];
  assign ir_val  = {{(DATA_W-15){ir[14]}}, ir[14:0]};

  // Classify the latched instruction and evaluate its condition against the flag register.
  always_comb begin
    is_alu_op  = ((ir_op >= 8'd1) && (ir_op <= 8'd31)) || (ir_op == OP_MVR);
    is_branch  = (ir_op == OP_JCP) || (ir_op == OP_JCD) || (ir_op == OP_JUA) ||
                 (ir_op == OP_JUP) || (ir_op == OP_JUD);
    is_illegal = !is_alu_op && !is_branch && (ir_op != OP_HALT) && (ir_op != OP_NOP);
    case (ir_cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flag_reg[FZ];
      3'd2:    cond_true = !flag_reg[FZ];
      3'd3:    cond_true = flag_reg[FC];
      3'd4:    cond_true = !flag_reg[FC];
      3'd5:    cond_true = flag_reg[FS];
      3'd6:    cond_true = !flag_reg[FS];
      default: cond_true = flag_reg[FV];
    endcase
  end

  // Main sequencer: fetch, decode/issue, execute, writeback and branch resolution.
  always_ff @(posedge clkout) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      flag_reg <= '0;
      illegal  <= 1'b0;
      opcode_r <= '0;
      a_r      <= '0;
      b_r      <= '0;
      val_r    <= '0;
      cin_r    <= 1'b0;
      fl_r     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (run) state <= FETCH;
        FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          opcode_r <= is_illegal ? OP_NOP : ir_op;
          a_r      <= regs[ir_rd];
          b_r      <= regs[ir_rs];
          val_r    <= ir_val;
          cin_r    <= flag_reg[FC];
          fl_r     <= cond_true;
          if (ir_op == OP_HALT) begin
            state <= HALT;
          end else if (is_branch) begin
            state <= BRANCH;
          end else if (is_alu_op) begin
            state <= EXEC;
          end else begin
            if (is_illegal) illegal <= 1'b1;
            pc    <= pc + 1'b1;
            state <= run ? FETCH : IDLE;
          end
        end
        EXEC: state <= WB;
        WB: begin
          regs[ir_rd] <= bus.alu_result;
          if ((ir_op >= 8'd1) && (ir_op <= 8'd31)) flag_reg <= bus.alu_flags;
          pc    <= pc + 1'b1;
          state <= run ? FETCH : IDLE;
        end
        BRANCH: begin
          case (ir_op)
            OP_JUD:  pc <= val_r[PC_W-1:0];
            OP_JUP:  pc <= pc + val_r[PC_W-1:0];
            OP_JUA:  pc <= regs[ir_rd][PC_W-1:0];
            OP_JCD:  pc <= fl_r ? val_r[PC_W-1:0] : pc + 1'b1;
            default: pc <= fl_r ? pc + val_r[PC_W-1:0] : pc + 1'b1;
          endcase
          state <= run ? FETCH : IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = (state == FETCH);
  assign bus.imem_addr  = pc;
  assign bus.alu_opcode = opcode_r;
  assign bus.alu_a      = a_r;
  assign bus.alu_b      = b_r;
  assign bus.alu_val    = val_r;
  assign bus.alu_cin    = cin_r;
  assign bus.alu_fl     = fl_r;
  assign pc_out         = pc;
  assign busy           = (state != IDLE) && (state != HALT);
  assign halted         = (state == HALT);

endmodule
